// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and lane-mask helper for the data memory controller.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // Big-endian lanes: mask bit 3 is bits [31:24], the byte at offset 0.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        m = '0;
        case (size)
            SZ_BYTE: m = 4'b1000 >> off;
            SZ_HALF: m = off[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: m = 4'b1111;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load path: picks the addressed big-endian lanes, right-justifies
// them and applies sign or zero extension.
module load_align_ext
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0: w_byte = i_word[31:24];
            2'd1: w_byte = i_word[23:16];
            2'd2: w_byte = i_word[15:8];
            2'd3: w_byte = i_word[7:0];
            default: w_byte = 8'h00;
        endcase
        w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];

        o_data = '0;
        case (i_size)
            SZ_BYTE: o_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_data = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            SZ_WORD: o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed big-endian data memory for the MEM stage: masked stores, extended
// loads, per-request fault check, two-stage registered response and post-reset clear.
//
// state    | meaning
// ST_CLEAR | zeroing one word per cycle, no requests accepted
// ST_IDLE  | accepting one request per cycle
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_BYTES    = 256,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqUnsigned,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic        RspValid,
    output logic [31:0] DataOut,
    output logic        Fault,
    output logic        Busy
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int IW    = AW - 2;

    logic [31:0]   r_mem [WORDS];
    state_t        r_state;
    logic [IW-1:0] r_clr_idx;
    logic          r_ready;
    logic          r_busy;

    logic          r_p_valid;
    logic          r_p_fault;
    logic          r_p_load;
    logic [31:0]   r_p_word;
    logic [1:0]    r_p_size;
    logic [1:0]    r_p_off;
    logic          r_p_uns;

    logic          r_rsp_valid;
    logic          r_fault;
    logic [31:0]   r_data_out;

    logic          w_accept;
    logic          w_fault;
    logic          w_store;
    logic [IW-1:0] w_idx;
    logic [3:0]    w_mask;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_aligned;

    assign w_accept  = ReqValid & r_ready;
    assign w_idx     = Address[AW-1:2];
    assign w_mask    = lane_mask(ReqSize, Address[1:0]);
    assign w_rd_word = r_mem[w_idx];
    assign w_store   = w_accept & ReqWrite & ~w_fault;

    always_comb begin
        w_fault = (ReqSize == 2'b11)
                | ((ReqSize == SZ_HALF) & Address[0])
                | ((ReqSize == SZ_WORD) & (|Address[1:0]))
                | (|Address[31:AW]);
        case (ReqSize)
            SZ_BYTE: w_wdata = {4{DataIn[7:0]}};
            SZ_HALF: w_wdata = {2{DataIn[15:0]}};
            default: w_wdata = DataIn;
        endcase
    end

    // Array has no reset; the CLEAR sequence is what gives it defined contents.
    always_ff @(posedge Clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_store) begin
            for (int l = 0; l < 4; l++) begin
                if (w_mask[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_clr_idx   <= '0;
            r_ready     <= 1'b0;
            r_busy      <= CLEAR_ON_RESET;
            r_p_valid   <= 1'b0;
            r_p_fault   <= 1'b0;
            r_p_load    <= 1'b0;
            r_p_word    <= '0;
            r_p_size    <= SZ_BYTE;
            r_p_off     <= '0;
            r_p_uns     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_fault     <= 1'b0;
            r_data_out  <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == IW'(WORDS - 1)) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase

            r_p_valid <= w_accept;
            r_p_fault <= w_accept & w_fault;
            r_p_load  <= w_accept & ~ReqWrite & ~w_fault;
            if (w_accept) begin
                r_p_word <= w_rd_word;
                r_p_size <= ReqSize;
                r_p_off  <= Address[1:0];
                r_p_uns  <= ReqUnsigned;
            end

            r_rsp_valid <= r_p_valid;
            r_fault     <= r_p_fault;
            r_data_out  <= r_p_load ? w_aligned : '0;
        end
    end

    load_align_ext u_align (
        .i_word     (r_p_word),
        .i_size     (r_p_size),
        .i_offset   (r_p_off),
        .i_unsigned (r_p_uns),
        .o_data     (w_aligned)
    );

    assign ReqReady = r_ready;
    assign Busy     = r_busy;
    assign RspValid = r_rsp_valid;
    assign Fault    = r_fault;
    assign DataOut  = r_data_out;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with DEPTH_BYTES = 64 and the clear sequence enabled.
module tb_data_memory_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic        ReqUnsigned = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] DataIn = '0;
    logic        ReqReady;
    logic        RspValid;
    logic [31:0] DataOut;
    logic        Fault;
    logic        Busy;

    int n_tests = 0;
    int n_fail  = 0;

    data_memory_ctrl #(.DEPTH_BYTES(64), .CLEAR_ON_RESET(1'b1)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqWrite    (ReqWrite),
        .ReqSize     (ReqSize),
        .ReqUnsigned (ReqUnsigned),
        .Address     (Address),
        .DataIn      (DataIn),
        .RspValid    (RspValid),
        .DataOut     (DataOut),
        .Fault       (Fault),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] din);
        ReqValid    = 1'b1;
        ReqWrite    = w;
        ReqSize     = sz;
        ReqUnsigned = uns;
        Address     = addr;
        DataIn      = din;
    endtask

    // One request, then the response two edges later.
    task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] din,
                        input logic [31:0] exp_data, input logic exp_fault);
        drive(w, sz, uns, addr, din);
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        @(posedge Clk); #1;
        check({tag, ".valid"}, {31'h0, RspValid}, 32'h1);
        check({tag, ".fault"}, {31'h0, Fault}, {31'h0, exp_fault});
        check({tag, ".data"}, DataOut, exp_data);
    endtask

    task automatic wait_clear(input string tag);
        int cyc;
        int ready_bad;
        int rsp_seen;
        cyc = 0;
        ready_bad = 0;
        rsp_seen = 0;
        while (Busy && cyc < 100) begin
            if (ReqReady) ready_bad++;
            if (RspValid) rsp_seen++;
            @(posedge Clk); #1;
            cyc++;
        end
        check({tag, ".len"}, cyc, 32'd16);
        check({tag, ".ready_low"}, ready_bad, 32'd0);
        check({tag, ".no_rsp"}, rsp_seen, 32'd0);
        check({tag, ".ready_up"}, {31'h0, ReqReady}, 32'h1);
    endtask

    initial begin
        @(posedge Clk); #1;
        check("rst.ready", {31'h0, ReqReady}, 32'h0);
        check("rst.valid", {31'h0, RspValid}, 32'h0);
        check("rst.data", DataOut, 32'h0);
        check("rst.fault", {31'h0, Fault}, 32'h0);
        check("rst.busy", {31'h0, Busy}, 32'h1);
        Reset = 1'b0;
        wait_clear("clr0");

        xfer("ld0", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'h0000_0000, 1'b0);

        xfer("st8", 1'b1, 2'b10, 1'b0, 32'd8, 32'h1122_3344, 32'h0, 1'b0);
        xfer("lbu9", 1'b0, 2'b00, 1'b1, 32'd9, 32'h0, 32'h0000_0022, 1'b0);
        xfer("lh10", 1'b0, 2'b01, 1'b0, 32'd10, 32'h0, 32'h0000_3344, 1'b0);
        xfer("lw8", 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'h1122_3344, 1'b0);

        @(posedge Clk); #1;
        check("gap.valid", {31'h0, RspValid}, 32'h0);
        check("gap.data", DataOut, 32'h0);

        xfer("st12", 1'b1, 2'b10, 1'b0, 32'd12, 32'hAABB_CCDD, 32'h0, 1'b0);
        xfer("sb12", 1'b1, 2'b00, 1'b0, 32'd12, 32'h0000_0080, 32'h0, 1'b0);
        xfer("lb12", 1'b0, 2'b00, 1'b0, 32'd12, 32'h0, 32'hFFFF_FF80, 1'b0);
        xfer("lw12", 1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 32'h80BB_CCDD, 1'b0);

        xfer("sh16", 1'b1, 2'b01, 1'b0, 32'd16, 32'h1234_8001, 32'h0, 1'b0);
        xfer("lhu16", 1'b0, 2'b01, 1'b1, 32'd16, 32'h0, 32'h0000_8001, 1'b0);
        xfer("lh16", 1'b0, 2'b01, 1'b0, 32'd16, 32'h0, 32'hFFFF_8001, 1'b0);

        xfer("st4", 1'b1, 2'b10, 1'b0, 32'd4, 32'h0102_0304, 32'h0, 1'b0);
        xfer("flw6", 1'b0, 2'b10, 1'b0, 32'd6, 32'h0, 32'h0, 1'b1);
        xfer("flw6.chk", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h0102_0304, 1'b0);
        xfer("fsh5", 1'b1, 2'b01, 1'b0, 32'd5, 32'h0000_FFFF, 32'h0, 1'b1);
        xfer("fsh5.chk", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h0102_0304, 1'b0);
        xfer("fsz3", 1'b1, 2'b11, 1'b0, 32'd4, 32'hDEAD_BEEF, 32'h0, 1'b1);
        xfer("fsz3.chk", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h0102_0304, 1'b0);
        xfer("frng", 1'b1, 2'b10, 1'b0, 32'd64, 32'hCAFE_F00D, 32'h0, 1'b1);
        xfer("frng.chk4", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h0102_0304, 1'b0);
        xfer("frng.chk0", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'h0000_0000, 1'b0);

        // Store then load on the very next cycle.
        drive(1'b1, 2'b01, 1'b0, 32'd2, 32'h0000_BEEF);
        @(posedge Clk); #1;
        drive(1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        check("b2b.st.valid", {31'h0, RspValid}, 32'h1);
        check("b2b.st.data", DataOut, 32'h0);
        @(posedge Clk); #1;
        check("b2b.ld.valid", {31'h0, RspValid}, 32'h1);
        check("b2b.ld.data", DataOut, 32'h0000_BEEF);
        check("b2b.ld.fault", {31'h0, Fault}, 32'h0);

        // Reset with a load in flight, then again part-way through clearing.
        drive(1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        ReqValid = 1'b0;
        #1;
        check("rst2.valid", {31'h0, RspValid}, 32'h0);
        check("rst2.busy", {31'h0, Busy}, 32'h1);
        @(posedge Clk); #1;
        check("rst2.valid_late", {31'h0, RspValid}, 32'h0);
        Reset = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        check("mid.busy", {31'h0, Busy}, 32'h1);
        check("mid.ready", {31'h0, ReqReady}, 32'h0);
        Reset = 1'b1;
        #1;
        check("mid.rst.ready", {31'h0, ReqReady}, 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
        wait_clear("clr1");
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        @(posedge Clk); #1;
        check("edge_req.valid", {31'h0, RspValid}, 32'h1);
        check("edge_req.data", DataOut, 32'h0);
        check("edge_req.fault", {31'h0, Fault}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
